// File: rtl/ieeedrv_pkg.sv
// ieeedrv_pkg: bus struct, handshake states and idle bus constant shared by host and drive
package ieeedrv_pkg;
  typedef struct packed {
    logic [7:0] data;
    logic       atn;
    logic       eoi;
    logic       dav;
    logic       nrfd;
    logic       ndac;
    logic       ifc;
    logic       ren;
    logic       srq;
  } st_ieee_bus;

  typedef enum logic [2:0] {
    IDLE,
    S_SETTLE,
    S_WAIT_RFD,
    S_DAV,
    S_WAIT_DAC,
    A_RDY,
    A_WAIT_DAV,
    A_WAIT_REL
  } hs_state_t;

  localparam st_ieee_bus IEEE_BUS_IDLE = '0;
endpackage

// File: rtl/ieee_hs_timer.sv
// ieee_hs_timer: ce-gated saturating 16-bit tick counter; done flags the tick that reaches limit
module ieee_hs_timer (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        clr,
  input  logic [15:0] limit,
  output logic        done
);
  logic [15:0] cnt;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (ce && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign done = ce && ({1'b0, cnt} + 17'd1 >= {1'b0, limit});
endmodule

// File: rtl/ieee_host_hs.sv
// ieee_host_hs: host-side IEEE-488 source/acceptor handshake engine between PET core streams and the bus
module ieee_host_hs
  import ieeedrv_pkg::*;
#(
  parameter int unsigned SETTLE_TICKS  = 2,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd65535
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  st_ieee_bus bus_i,
  output st_ieee_bus bus_o,
  input  logic       listen,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  input  logic       tx_atn,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_eoi,
  input  logic       rx_ready,
  output logic       err_nodev,
  output logic       err_timeout,
  input  logic       err_clr,
  output logic       busy
);
  hs_state_t state, state_d;
  st_ieee_bus bus_d;
  logic rx_valid_d, rx_eoi_d, set_nodev, set_to, tmr_done, timed_out;
  logic [7:0] rx_data_d;
  logic [15:0] tmr_limit;
  logic unused_bus;

  assign unused_bus = ^{bus_i.atn, bus_i.ren, bus_i.srq};
  assign busy = state != IDLE;
  assign tmr_limit = (state == S_SETTLE) ? 16'(SETTLE_TICKS) : TIMEOUT_TICKS;
  assign timed_out = tmr_done && (state inside {S_WAIT_RFD, S_WAIT_DAC, A_WAIT_REL});

  ieee_hs_timer u_timer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce      (ce),
    .clr     (state_d != state),
    .limit   (tmr_limit),
    .done    (tmr_done)
  );

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state       <= IDLE;
      bus_o       <= IEEE_BUS_IDLE;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_eoi      <= 1'b0;
      err_nodev   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      bus_o       <= bus_d;
      rx_valid    <= rx_valid_d;
      rx_data     <= rx_data_d;
      rx_eoi      <= rx_eoi_d;
      err_nodev   <= set_nodev | (err_nodev & ~err_clr);
      err_timeout <= set_to | (err_timeout & ~err_clr);
    end

  always_comb begin
    state_d    = state;
    bus_d      = bus_o;
    rx_valid_d = rx_valid & ~rx_ready;
    rx_data_d  = rx_data;
    rx_eoi_d   = rx_eoi;
    set_nodev  = 1'b0;
    set_to     = 1'b0;
    tx_ready   = 1'b0;
    if (bus_i.ifc) begin
      state_d    = IDLE;
      bus_d      = IEEE_BUS_IDLE;
      rx_valid_d = 1'b0;
    end else if (timed_out) begin
      set_to  = 1'b1;
      state_d = IDLE;
      bus_d   = IEEE_BUS_IDLE;
    end else begin
      case (state)
        IDLE:
          if (!listen && tx_valid) begin
            tx_ready   = 1'b1;
            state_d    = S_SETTLE;
            bus_d      = IEEE_BUS_IDLE;
            bus_d.data = tx_data;
            bus_d.eoi  = tx_eoi;
            bus_d.atn  = tx_atn;
          end else if (listen && !rx_valid) state_d = A_RDY;
          else if (!listen) bus_d = IEEE_BUS_IDLE;
        S_SETTLE:
          if (tmr_done) begin
            // Nobody pulling either acceptor line means the bus is empty
            if (!bus_i.nrfd && !bus_i.ndac) begin
              set_nodev = 1'b1;
              state_d   = IDLE;
              bus_d     = IEEE_BUS_IDLE;
            end else state_d = S_WAIT_RFD;
          end
        S_WAIT_RFD:
          if (!bus_i.nrfd) begin
            bus_d.dav = 1'b1;
            state_d   = S_DAV;
          end
        S_DAV: state_d = S_WAIT_DAC;
        S_WAIT_DAC:
          if (!bus_i.ndac) begin
            bus_d     = IEEE_BUS_IDLE;
            bus_d.atn = tx_valid & tx_atn & ~listen;
            state_d   = IDLE;
          end
        A_RDY: begin
          bus_d      = IEEE_BUS_IDLE;
          bus_d.ndac = 1'b1;
          state_d    = A_WAIT_DAV;
        end
        A_WAIT_DAV:
          if (bus_i.dav) begin
            rx_data_d  = bus_i.data;
            rx_eoi_d   = bus_i.eoi;
            rx_valid_d = 1'b1;
            bus_d.nrfd = 1'b1;
            state_d    = A_WAIT_REL;
          end
        A_WAIT_REL:
          // NDAC is released one cycle after NRFD goes up, before watching DAV
          if (bus_o.ndac) bus_d.ndac = 1'b0;
          else if (!bus_i.dav) begin
            bus_d.ndac = 1'b1;
            state_d    = IDLE;
          end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ieee_host_hs.sv
// tb_ieee_host_hs: directed bench with model listener/talker on a wired-OR bus
module tb_ieee_host_hs;
  import ieeedrv_pkg::*;

  logic clk_sys = 1'b0, reset = 1'b0, ce = 1'b1;
  logic listen = 1'b0, tx_valid = 1'b0, tx_eoi = 1'b0, tx_atn = 1'b0, rx_ready = 1'b0, err_clr = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_ready, rx_valid, rx_eoi, err_nodev, err_timeout, busy;
  logic [7:0] rx_data;
  logic lst_en = 1'b0, lst_freeze = 1'b0, t_dav = 1'b0, t_eoi = 1'b0, ifc = 1'b0;
  logic [7:0] t_data = '0;
  st_ieee_bus mdl, bus_i, bus_o;
  int checks = 0, failures = 0;

  always #5 clk_sys = ~clk_sys;

  always_comb begin
    mdl      = IEEE_BUS_IDLE;
    mdl.nrfd = lst_en & bus_o.dav;
    mdl.ndac = lst_en & (lst_freeze | ~bus_o.dav);
    mdl.data = t_data;
    mdl.eoi  = t_eoi;
    mdl.dav  = t_dav;
    mdl.ifc  = ifc;
  end
  assign bus_i = bus_o | mdl;

  ieee_host_hs #(.SETTLE_TICKS(2), .TIMEOUT_TICKS(16'd16)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .bus_i(bus_i), .bus_o(bus_o),
    .listen(listen), .tx_valid(tx_valid), .tx_data(tx_data), .tx_eoi(tx_eoi),
    .tx_atn(tx_atn), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_eoi(rx_eoi), .rx_ready(rx_ready), .err_nodev(err_nodev),
    .err_timeout(err_timeout), .err_clr(err_clr), .busy(busy)
  );

  task automatic talk(input logic [7:0] d, input logic e, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_sys);
      if (!bus_i.nrfd && bus_i.ndac) ok = 1;
    end
    if (!ok) return;
    t_data = d; t_eoi = e;
    @(negedge clk_sys);
    t_dav = 1; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_sys);
      if (!bus_i.ndac) ok = 1;
    end
    t_dav = 0; t_data = 0; t_eoi = 0;
  endtask

  task automatic test_reset;
    #1 reset = 1;
    repeat (2) @(negedge clk_sys);
    checks++; if (bus_o !== IEEE_BUS_IDLE) begin failures++; $display("FAIL reset_bus got %h want %h", bus_o, IEEE_BUS_IDLE); end
    checks++; if ({tx_ready, rx_valid, rx_eoi, err_nodev, err_timeout, busy} !== 6'b0) begin failures++; $display("FAIL reset_flags got %b want 000000", {tx_ready, rx_valid, rx_eoi, err_nodev, err_timeout, busy}); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    reset = 0;
    @(negedge clk_sys);
  endtask

  task automatic test_source;
    int n_rise = 0, n_fall = 0, n_rdy = 0;
    logic [7:0] d_seen = '0;
    lst_en = 1; lst_freeze = 0;
    @(negedge clk_sys);
    tx_data = 8'h41; tx_eoi = 0; tx_atn = 0; tx_valid = 1;
    #1;
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL src_tx_ready got %b want 1", tx_ready); end
    @(posedge clk_sys); #1 tx_valid = 0; tx_data = 0;
    for (int n = 1; n <= 20 && n_fall == 0; n++) begin
      @(negedge clk_sys);
      if (tx_ready) n_rdy++;
      if (bus_o.dav && n_rise == 0) begin n_rise = n; d_seen = bus_o.data; end
      if (!bus_o.dav && n_rise != 0) n_fall = n;
    end
    checks++; if (n_rise != 4) begin failures++; $display("FAIL src_dav_rise got %0d want 4", n_rise); end
    checks++; if (d_seen !== 8'h41) begin failures++; $display("FAIL src_data got %h want 41", d_seen); end
    checks++; if (n_fall != 6) begin failures++; $display("FAIL src_dav_fall got %0d want 6", n_fall); end
    checks++; if (n_rdy != 0) begin failures++; $display("FAIL src_extra_ready got %0d want 0", n_rdy); end
    checks++; if (bus_o !== IEEE_BUS_IDLE || busy !== 1'b0) begin failures++; $display("FAIL src_end got bus=%h busy=%b want idle/0", bus_o, busy); end
  endtask

  task automatic test_back_to_back;
    int taken = 0;
    bit gap = 0;
    logic prev_dav = 0;
    logic [7:0] seen[$];
    lst_en = 1; lst_freeze = 0;
    @(negedge clk_sys);
    tx_data = 8'h28; tx_atn = 1; tx_eoi = 0; tx_valid = 1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (tx_ready) begin
        taken++;
        @(posedge clk_sys); #1;
        if (taken == 1) tx_data = 8'h6F;
        else begin tx_valid = 0; tx_atn = 0; end
      end
      @(negedge clk_sys);
      if (bus_o.dav && !prev_dav) seen.push_back(bus_o.data);
      prev_dav = bus_o.dav;
      if (taken >= 1 && !(taken == 2 && !busy) && !bus_o.atn) gap = 1;
      if (taken == 2 && !busy) break;
    end
    checks++; if (taken != 2) begin failures++; $display("FAIL cmd_taken got %0d want 2", taken); end
    checks++; if (gap) begin failures++; $display("FAIL cmd_atn_gap got 1 want 0"); end
    checks++; if (seen.size() != 2) begin failures++; $display("FAIL cmd_count got %0d want 2", seen.size()); end
    else begin
      checks++; if (seen[0] !== 8'h28 || seen[1] !== 8'h6F) begin failures++; $display("FAIL cmd_bytes got %h %h want 28 6f", seen[0], seen[1]); end
    end
    checks++; if (bus_o.atn !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL cmd_atn_drop got atn=%b busy=%b want 0/0", bus_o.atn, busy); end
  endtask

  task automatic test_nodev;
    lst_en = 0;
    @(negedge clk_sys);
    tx_data = 8'h55; tx_valid = 1;
    @(posedge clk_sys); #1 tx_valid = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_sys);
      if (!busy) break;
    end
    checks++; if (err_nodev !== 1'b1 || err_timeout !== 1'b0) begin failures++; $display("FAIL nodev_flag got nodev=%b to=%b want 1/0", err_nodev, err_timeout); end
    checks++; if (bus_o !== IEEE_BUS_IDLE || busy !== 1'b0) begin failures++; $display("FAIL nodev_bus got bus=%h busy=%b want idle/0", bus_o, busy); end
    err_clr = 1;
    @(negedge clk_sys); err_clr = 0;
    checks++; if (err_nodev !== 1'b0) begin failures++; $display("FAIL nodev_clr got %b want 0", err_nodev); end
  endtask

  task automatic test_timeout;
    int n_dav = 0, n_err = 0;
    logic eoi_seen = 0;
    lst_en = 1; lst_freeze = 1;
    @(negedge clk_sys);
    tx_data = 8'h99; tx_eoi = 1; tx_valid = 1;
    @(posedge clk_sys); #1 tx_valid = 0; tx_eoi = 0;
    for (int n = 1; n <= 40 && n_err == 0; n++) begin
      @(negedge clk_sys);
      if (bus_o.dav && n_dav == 0) begin n_dav = n; eoi_seen = bus_o.eoi; end
      if (err_timeout) n_err = n;
    end
    checks++; if (n_dav != 4 || eoi_seen !== 1'b1) begin failures++; $display("FAIL to_dav got n=%0d eoi=%b want 4/1", n_dav, eoi_seen); end
    checks++; if (n_err != 21) begin failures++; $display("FAIL to_cycle got %0d want 21", n_err); end
    checks++; if (bus_o !== IEEE_BUS_IDLE || busy !== 1'b0) begin failures++; $display("FAIL to_release got bus=%h busy=%b want idle/0", bus_o, busy); end
    lst_en = 0; lst_freeze = 0;
    err_clr = 1;
    @(negedge clk_sys); err_clr = 0;
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_clr got %b want 0", err_timeout); end
  endtask

  task automatic test_listen;
    bit ok;
    listen = 1;
    talk(8'h0D, 1'b1, ok);
    @(negedge clk_sys);
    checks++; if (!ok) begin failures++; $display("FAIL lst_hs1 got stall want handshake"); end
    checks++; if ({rx_valid, rx_eoi, rx_data} !== {1'b1, 1'b1, 8'h0D}) begin failures++; $display("FAIL lst_rx1 got v=%b e=%b d=%h want 1/1/0d", rx_valid, rx_eoi, rx_data); end
    repeat (4) @(negedge clk_sys);
    checks++; if (bus_o.nrfd !== 1'b1 || rx_valid !== 1'b1) begin failures++; $display("FAIL lst_backpressure got nrfd=%b v=%b want 1/1", bus_o.nrfd, rx_valid); end
    rx_ready = 1;
    @(negedge clk_sys); rx_ready = 0;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL lst_take got %b want 0", rx_valid); end
    talk(8'h55, 1'b0, ok);
    @(negedge clk_sys);
    checks++; if (!ok || {rx_valid, rx_eoi, rx_data} !== {1'b1, 1'b0, 8'h55}) begin failures++; $display("FAIL lst_rx2 got ok=%b v=%b e=%b d=%h want 1/1/0/55", ok, rx_valid, rx_eoi, rx_data); end
    rx_ready = 1;
    @(negedge clk_sys); rx_ready = 0;
  endtask

  task automatic test_ifc;
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_sys);
      if (!bus_i.nrfd && bus_i.ndac) ok = 1;
    end
    t_data = 8'h77; t_dav = 1; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_sys);
      if (!bus_i.ndac) ok = 1;
    end
    checks++; if (!ok || rx_valid !== 1'b1 || rx_data !== 8'h77) begin failures++; $display("FAIL ifc_setup got ok=%b v=%b d=%h want 1/1/77", ok, rx_valid, rx_data); end
    ifc = 1;
    #1;
    checks++; if (bus_o.nrfd !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL ifc_early got nrfd=%b busy=%b want 1/1", bus_o.nrfd, busy); end
    @(posedge clk_sys); #1;
    checks++; if (bus_o !== IEEE_BUS_IDLE || rx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ifc_release got bus=%h v=%b busy=%b want idle/0/0", bus_o, rx_valid, busy); end
    @(negedge clk_sys);
    listen = 0; t_dav = 0; t_data = 0;
    @(negedge clk_sys); ifc = 0;
    @(negedge clk_sys);
  endtask

  task automatic test_async_reset;
    bit hit = 0;
    lst_en = 1; lst_freeze = 0;
    tx_data = 8'h33; tx_valid = 1;
    @(posedge clk_sys); #1 tx_valid = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk_sys);
      if (bus_o.dav) hit = 1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL rst_reach_dav got no dav want dav"); end
    reset = 1;
    #1;
    checks++; if (bus_o !== IEEE_BUS_IDLE || busy !== 1'b0) begin failures++; $display("FAIL rst_async got bus=%h busy=%b want idle/0", bus_o, busy); end
    @(negedge clk_sys); reset = 0;
    @(negedge clk_sys);
    checks++; if (busy !== 1'b0 || rx_valid !== 1'b0 || bus_o !== IEEE_BUS_IDLE) begin failures++; $display("FAIL rst_after got busy=%b v=%b bus=%h want 0/0/idle", busy, rx_valid, bus_o); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_source();
    test_back_to_back();
    test_nodev();
    test_timeout();
    test_listen();
    test_ifc();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ieee_host_hs.md
Name: ieee_host_hs

Overview:
- Controller/computer-side IEEE-488 byte-transfer engine. It is the opposite end of the drive's bus interface.
- Acts as Source Handshake (talker/commander) or Acceptor Handshake (listener) on the three-wire DAV/NRFD/NDAC protocol.
- Exchanges bytes with the PET core through valid/ready streams.
- Sits between the CPU's PIA/VIA IEEE port logic and the shared st_ieee_bus wired-OR fabric that also feeds the drive model.

Parameters:
- SETTLE_TICKS, 2, ce ticks data/ATN/EOI must be stable before DAV is asserted.
- TIMEOUT_TICKS, 16'd65535, ce ticks allowed in any handshake wait state before the error abort.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  timing tick; all tick counters advance only when ce=1.
- bus_i  in  st_ieee_bus  resolved bus state (wired-OR of all devices).
- bus_o  out  st_ieee_bus  this block's drive contribution.
- listen  in  1  0 = source mode, 1 = acceptor mode; sampled only in IDLE.
- tx_valid  in  1  byte offered for transmission.
- tx_data  in  8  byte to send.
- tx_eoi  in  1  assert EOI with this byte.
- tx_atn  in  1  send as command byte (ATN asserted).
- tx_ready  out  1  tx byte taken (one-cycle pulse).
- rx_valid  out  1  received byte available.
- rx_data  out  8  received byte.
- rx_eoi  out  1  EOI accompanied rx_data.
- rx_ready  in  1  consumer takes rx byte.
- err_nodev  out  1  sticky; no listener present.
- err_timeout  out  1  sticky; handshake timeout.
- err_clr  in  1  clears both sticky errors.
- busy  out  1  state != IDLE.

Behaviour:
- Bus encoding: st_ieee_bus fields (data[7:0], atn, eoi, dav, nrfd, ndac, ifc, ren, srq) are logically asserted-high. Inversion to the physical wire is done elsewhere. bus_o fields this block does not own are driven 0.
- Reset values: all bus_o fields 0; tx_ready 0; rx_valid 0; rx_data 0; rx_eoi 0; err_nodev 0; err_timeout 0; busy 0; state IDLE; counters 0.
- State machine: IDLE, S_SETTLE, S_WAIT_RFD, S_DAV, S_WAIT_DAC, A_RDY, A_WAIT_DAV, A_WAIT_REL.
- IDLE
  - If listen=0 and tx_valid=1: latch tx_data/tx_eoi/tx_atn and drive them on bus_o; go to S_SETTLE.
  - If listen=1 and rx_valid=0: go to A_RDY.
  - tx_ready pulses for exactly one cycle on the transition IDLE->S_SETTLE.
- S_SETTLE
  - Counts SETTLE_TICKS ce ticks.
  - Then, if bus_i.nrfd=0 and bus_i.ndac=0, no device is present: set err_nodev, release all lines, go to IDLE.
  - Otherwise go to S_WAIT_RFD.
- S_WAIT_RFD: wait for bus_i.nrfd=0, then drive dav=1 and go to S_DAV.
- S_DAV: go to S_WAIT_DAC after one cycle (DAV registered).
- S_WAIT_DAC: wait for bus_i.ndac=0, then drop dav, data, eoi and atn together and return to IDLE.
  - Exception: atn stays asserted if the next tx_valid with tx_atn=1 is already present, so multi-byte command sequences keep ATN continuous.
  - Total source latency with instant listeners: SETTLE_TICKS ticks + 3 clk_sys cycles.
- A_RDY: drive ndac=1, nrfd=0, go to A_WAIT_DAV.
- A_WAIT_DAV
  - On bus_i.dav=1: latch rx_data=bus_i.data and rx_eoi=bus_i.eoi.
  - Drive nrfd=1, then ndac=0 one cycle later.
  - rx_valid=1; go to A_WAIT_REL.
- A_WAIT_REL: wait for bus_i.dav=0, then drive ndac=1 (nrfd stays 1) and go to IDLE.
- rx_valid
  - Clears on the cycle rx_ready=1. rx_valid and rx_ready at the same cycle as a new latch is impossible, because the acceptor only re-arms when rx_valid=0.
  - While rx_valid=1 and listen=1, nrfd is held asserted: backpressure to the talker.
- Timeout: every wait state (S_WAIT_RFD, S_WAIT_DAC, A_WAIT_DAV excluded, A_WAIT_REL) counts ce ticks.
  - Reaching TIMEOUT_TICKS sets err_timeout, releases all driven lines, and returns to IDLE.
  - A_WAIT_DAV waits indefinitely (idle listener is legal).
- bus_i.ifc=1 in any state: release all lines, drop rx_valid, go to IDLE in the next cycle. Sticky errors are not touched.
- Mode change: listen toggling outside IDLE is ignored until IDLE.
- err_clr has priority below a same-cycle error set (the set wins).
- Arithmetic: the tick counter is 16-bit, saturating, and cleared on every state entry.

Decomposition:
- Shared package ieeedrv_pkg holds:
  - st_ieee_bus (already shared with the drive).
  - Enum hs_state_t.
  - Constant IEEE_BUS_IDLE (all-zero bus struct).
- One natural sub-module, ieee_hs_timer: a ce-gated, saturating 16-bit counter with clear and a terminal flag, used for both settle and timeout.

Test Plan:
- Source to a model listener with zero delay, SETTLE_TICKS=2, tx 0x41 eoi=0 atn=0:
  - bus data=0x41, DAV rises after 2 ce ticks, falls within 1 cycle of NDAC release.
  - tx_ready pulses once.
- Command sequence 0x28,0x6F with tx_atn=1 back-to-back: ATN stays 1 across both bytes and drops after the second NDAC release.
- Source with no device (nrfd=0, ndac=0 after settle): err_nodev=1, bus_o==IEEE_BUS_IDLE, busy=0; err_clr then clears it.
- Listen mode, model talker sends 0x0D with EOI:
  - rx_valid=1, rx_data=0x0D, rx_eoi=1.
  - NRFD remains asserted until rx_ready is pulsed, then the next byte is accepted.
- Listener freezes NDAC with TIMEOUT_TICKS=16: err_timeout after 16 ce ticks in S_WAIT_DAC; all lines released.
- Assert reset asynchronously mid-S_DAV, and separately assert ifc mid-A_WAIT_REL: bus_o returns to idle (immediately for reset, next cycle for ifc), rx_valid=0, state IDLE.
